// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared FSM states, 7-segment patterns and power-of-ten helper
package seg7_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CONVERT = 2'd1;
    localparam logic [1:0] ST_UPDATE  = 2'd2;

    // Active-low gfedcba patterns
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/seg7_digit_encoder.sv
// rtl/seg7_digit_encoder.sv - BCD nibble to active-low 7-segment pattern
module seg7_digit_encoder
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] segments
);

    always_comb begin
        case (digit)
            4'd0:    segments = SEG_0;
            4'd1:    segments = SEG_1;
            4'd2:    segments = SEG_2;
            4'd3:    segments = SEG_3;
            4'd4:    segments = SEG_4;
            4'd5:    segments = SEG_5;
            4'd6:    segments = SEG_6;
            4'd7:    segments = SEG_7;
            4'd8:    segments = SEG_8;
            4'd9:    segments = SEG_9;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/multi_digit_bcd_display.sv
// rtl/multi_digit_bcd_display.sv - sequential binary-to-BCD converter driving a multi-digit 7-segment display
module multi_digit_bcd_display
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BIN_WIDTH  = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [BIN_WIDTH-1:0]    in_value,
    input  logic                    in_blank_lz,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [NUM_DIGITS*7-1:0] hex,
    output logic                    overflow,
    output logic                    done
);

    localparam int          BCD_W = NUM_DIGITS * 4 + 4;
    localparam int          CNT_W = $clog2(BIN_WIDTH + 1);
    localparam logic [63:0] LIMIT = pow10(NUM_DIGITS) - 64'd1;

    logic [1:0]              state_q;
    logic [BIN_WIDTH-1:0]    value_q;
    logic [BIN_WIDTH-1:0]    shift_q;
    logic [BCD_W-1:0]        bcd_q;
    logic [CNT_W-1:0]        cnt_q;
    logic                    blank_q;

    logic [BCD_W-1:0]        adj;
    logic [BCD_W-1:0]        bcd_next;
    logic [NUM_DIGITS*7-1:0] seg_enc;
    logic [NUM_DIGITS*7-1:0] hex_next;
    logic                    ovf_next;
    logic                    leading;

    assign in_ready = (state_q == ST_IDLE);

    // One double-dabble step: add 3 to every nibble >= 5, then shift in the next binary MSB
    always_comb begin
        adj = bcd_q;
        for (int d = 0; d < NUM_DIGITS + 1; d++) begin
            if (adj[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
            end
        end
        bcd_next = (adj << 1) | BCD_W'(shift_q[BIN_WIDTH-1]);
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_enc
            seg7_digit_encoder u_enc (
                .digit    (bcd_q[4*g +: 4]),
                .segments (seg_enc[7*g +: 7])
            );
        end
    endgenerate

    assign ovf_next = (64'(value_q) > LIMIT);

    // Walk from the top digit down; blanking stops at the first nonzero digit and never reaches digit 0
    always_comb begin
        hex_next = '1;
        leading  = blank_q;
        for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
            if (bcd_q[4*d +: 4] != 4'd0) begin
                leading = 1'b0;
            end
            if (ovf_next) begin
                hex_next[7*d +: 7] = SEG_DASH;
            end else if (leading && (d != 0)) begin
                hex_next[7*d +: 7] = SEG_BLANK;
            end else begin
                hex_next[7*d +: 7] = seg_enc[7*d +: 7];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            value_q  <= '0;
            shift_q  <= '0;
            bcd_q    <= '0;
            cnt_q    <= '0;
            blank_q  <= 1'b0;
            hex      <= '1;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        value_q <= in_value;
                        shift_q <= in_value;
                        blank_q <= in_blank_lz;
                        bcd_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    bcd_q   <= bcd_next;
                    shift_q <= shift_q << 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(BIN_WIDTH - 1)) begin
                        state_q <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    hex      <= hex_next;
                    overflow <= ovf_next;
                    done     <= 1'b1;
                    state_q  <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/multi_digit_bcd_display.md
MULTI_DIGIT_BCD_DISPLAY -- requirements
Module: multi_digit_bcd_display

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6, number of 7-segment digits driven; legal range 1..8.
REQ-002 SHALL have parameter BIN_WIDTH, default 20, width of the binary input value; legal range 4..27.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_value, input, BIN_WIDTH, unsigned binary value to display.
REQ-006 SHALL have port in_blank_lz, input, 1, leading-zero blanking request, sampled with in_value.
REQ-007 SHALL have port in_valid, input, 1, load request.
REQ-008 SHALL have port in_ready, output, 1, high when a load can be accepted.
REQ-009 SHALL have port hex, output, NUM_DIGITS*7, active-low segment patterns (gfedcba); digit i at bits [7i+6:7i]; digit 0 least significant.
REQ-010 SHALL have port overflow, output, 1, high while the displayed value exceeds 10^NUM_DIGITS-1.
REQ-011 SHALL have port done, output, 1, one-cycle pulse when hex/overflow update.

Function
REQ-012 SHALL accept a load on any rising edge with in_valid=1 and in_ready=1, capturing in_value and in_blank_lz.
REQ-013 SHALL implement states IDLE (in_ready=1), CONVERT (in_ready=0), UPDATE (in_ready=0); IDLE->CONVERT on load, CONVERT->UPDATE after BIN_WIDTH cycles, UPDATE->IDLE after one cycle.
REQ-014 SHALL convert binary to BCD sequentially by shift-and-add-3 (double dabble), one input bit per CONVERT cycle, MSB first, on a (NUM_DIGITS*4+4)-bit BCD register.
REQ-015 SHALL update hex, overflow and pulse done in UPDATE, i.e. exactly BIN_WIDTH+1 cycles after the accepting edge; in_ready returns high the following cycle.
REQ-016 SHALL hold hex and overflow unchanged between updates.
REQ-017 SHALL encode digits 0..9 as 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000; any other BCD nibble as 1111111.
REQ-018 SHALL, when captured in_blank_lz=1, drive 1111111 on every zero digit above the most significant nonzero digit; digit 0 is never blanked (value 0 shows "0").
REQ-019 SHALL, when the captured value > 10^NUM_DIGITS-1, set overflow=1 and drive 0111111 (dash) on all digits regardless of blanking; else overflow=0.
REQ-020 SHALL ignore in_valid while in_ready=0; no queuing, captured operands unaffected.
REQ-021 SHALL accept a back-to-back load on the first cycle in_ready is high again.

Reset
REQ-022 SHALL, on reset assertion at any time (including mid-conversion), immediately force state IDLE, hex all 1s (blank), overflow=0, done=0, in_ready=1, BCD/shift registers cleared.
REQ-023 SHALL accept no load while reset is high; the aborted conversion SHALL never produce an update.

Structure
REQ-024 SHALL place the state enumeration, the 7-segment digit/blank/dash constants and a 10^N power-limit function in a shared package seg7_pkg.
REQ-025 SHALL use one sub-module, seg7_digit_encoder (combinational nibble -> active-low pattern), instantiated NUM_DIGITS times.

Verification (NUM_DIGITS=6, BIN_WIDTH=20)
REQ-026 SHALL check reset: after reset release hex=42'h3FFFFFFFFFF, overflow=0, done=0, in_ready=1.
REQ-027 SHALL check load 123456, blank_lz=0 -> done 21 cycles later; digits 5..0 = 1111001,0100100,0110000,0011001,0010010,0000010; overflow=0.
REQ-028 SHALL check load 42, blank_lz=1 -> digits 5..2 = 1111111, digit1=0011001, digit0=0100100; load 0, blank_lz=1 -> digit0=1000000, others 1111111.
REQ-029 SHALL check load 1000000 -> all digits 0111111, overflow=1; then load 999999 -> all digits 0010000, overflow=0.
REQ-030 SHALL check in_valid with 777 during CONVERT of 5 -> ignored, display shows 5 only; reset asserted at CONVERT cycle 10 -> outputs blank at once, no done pulse, in_ready=1 after release.
